// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter for the shared RV32I memory bus: instruction fetch vs load/store.
// Optional access timeout is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        iClk,
    input  logic        nRst,
    input  logic        iIfReq,
    input  logic [31:0] iIfAddr,
    output logic        oIfRdy,
    output logic [31:0] oIfData,
    input  logic        iDReq,
    input  logic        iDWe,
    input  logic [31:0] iDAddr,
    input  logic [31:0] iDWData,
    input  logic [3:0]  iDBe,
    output logic        oDRdy,
    output logic [31:0] oDRData,
    output logic        oBusErr,
    output logic [31:0] oMemAddr,
    output logic [31:0] oMemData,
    output logic [3:0]  oMemBe,
    output logic        oMemRead,
    output logic        oMemWrite,
    input  logic [31:0] iMemData,
    input  logic        iMemRdy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_ACC = 2'd1,
        D_ACC  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        last_d, last_d_nxt;
    logic        gnt_if, gnt_d;
    logic [31:0] addr_nxt, wdata_nxt, if_data_nxt, d_rdata_nxt;
    logic [3:0]  be_nxt;
    logic        rd_nxt, wr_nxt, if_rdy_nxt, d_rdy_nxt;

`ifdef MEM_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             err_nxt;
`else
    localparam int cfg_unused = TIMEOUT_CYCLES + CNT_W;
    assign oBusErr = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        last_d_nxt  = last_d;
        addr_nxt    = oMemAddr;
        wdata_nxt   = oMemData;
        be_nxt      = oMemBe;
        rd_nxt      = oMemRead;
        wr_nxt      = oMemWrite;
        if_rdy_nxt  = 1'b0;
        d_rdy_nxt   = 1'b0;
        if_data_nxt = oIfData;
        d_rdata_nxt = oDRData;
        // Round-robin: on a tie the port that was not granted last wins
        gnt_if      = iIfReq && (!iDReq || last_d);
        gnt_d       = iDReq && (!iIfReq || !last_d);
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_nxt     = cnt;
        err_nxt     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (gnt_if) begin
                    state_nxt  = IF_ACC;
                    last_d_nxt = 1'b0;
                    addr_nxt   = {iIfAddr[31:2], 2'b00};
                    wdata_nxt  = 32'h0;
                    be_nxt     = 4'hF;
                    rd_nxt     = 1'b1;
                    wr_nxt     = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
                    cnt_nxt    = '0;
`endif
                end else if (gnt_d) begin
                    state_nxt  = D_ACC;
                    last_d_nxt = 1'b1;
                    addr_nxt   = {iDAddr[31:2], 2'b00};
                    wdata_nxt  = iDWData;
                    be_nxt     = iDBe;
                    rd_nxt     = !iDWe;
                    wr_nxt     = iDWe;
`ifdef MEM_ARB_TIMEOUT_EN
                    cnt_nxt    = '0;
`endif
                end
            end
            IF_ACC, D_ACC: begin
                if (iMemRdy) begin
                    state_nxt = IDLE;
                    rd_nxt    = 1'b0;
                    wr_nxt    = 1'b0;
                    if (state == IF_ACC) begin
                        if_rdy_nxt  = 1'b1;
                        if_data_nxt = iMemData;
                    end else begin
                        d_rdy_nxt = 1'b1;
                        if (oMemRead) begin
                            d_rdata_nxt = iMemData;
                        end
                    end
                end
`ifdef MEM_ARB_TIMEOUT_EN
                // A ready on the limit cycle takes precedence over the timeout
                else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt = IDLE;
                    rd_nxt    = 1'b0;
                    wr_nxt    = 1'b0;
                    err_nxt   = 1'b1;
                    if (state == IF_ACC) begin
                        if_rdy_nxt  = 1'b1;
                        if_data_nxt = 32'h0;
                    end else begin
                        d_rdy_nxt   = 1'b1;
                        d_rdata_nxt = 32'h0;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
                rd_nxt    = 1'b0;
                wr_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!nRst) begin
            state     <= IDLE;
            last_d    <= 1'b0;
            oMemAddr  <= 32'h0;
            oMemData  <= 32'h0;
            oMemBe    <= 4'h0;
            oMemRead  <= 1'b0;
            oMemWrite <= 1'b0;
            oIfRdy    <= 1'b0;
            oDRdy     <= 1'b0;
            oIfData   <= 32'h0;
            oDRData   <= 32'h0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt       <= '0;
            oBusErr   <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            last_d    <= last_d_nxt;
            oMemAddr  <= addr_nxt;
            oMemData  <= wdata_nxt;
            oMemBe    <= be_nxt;
            oMemRead  <= rd_nxt;
            oMemWrite <= wr_nxt;
            oIfRdy    <= if_rdy_nxt;
            oDRdy     <= d_rdy_nxt;
            oIfData   <= if_data_nxt;
            oDRData   <= d_rdata_nxt;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt       <= cnt_nxt;
            oBusErr   <= err_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed bus scenarios, then random traffic against a word-memory model.
// Timeout scenario runs only when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        nrst;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        if_rdy, d_rdy, bus_err;
    logic [31:0] if_data, d_rdata;
    logic [31:0] mem_addr, mem_data;
    logic [3:0]  mem_be;
    logic        mem_read, mem_write;
    logic [31:0] mem_rdata;
    logic        mem_rdy;

    // manual vs automatic bus responder
    logic        auto_en;
    logic        m_rdy, a_rdy;
    logic [31:0] m_data, a_data;
    assign mem_rdy   = auto_en ? a_rdy : m_rdy;
    assign mem_rdata = auto_en ? a_data : m_data;

    int total;
    int passed;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .iClk(clk), .nRst(nrst),
        .iIfReq(if_req), .iIfAddr(if_addr), .oIfRdy(if_rdy), .oIfData(if_data),
        .iDReq(d_req), .iDWe(d_we), .iDAddr(d_addr), .iDWData(d_wdata), .iDBe(d_be),
        .oDRdy(d_rdy), .oDRData(d_rdata), .oBusErr(bus_err),
        .oMemAddr(mem_addr), .oMemData(mem_data), .oMemBe(mem_be),
        .oMemRead(mem_read), .oMemWrite(mem_write),
        .iMemData(mem_rdata), .iMemRdy(mem_rdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = w[i*8 +: 8];
        return r;
    endfunction

    // Bus-side memory seen by the responder (written from the DUT's bus outputs)
    logic [31:0] bus_mem [logic [31:0]];
    logic [31:0] seen_addr, seen_wdata;
    logic [3:0]  seen_be;
    logic        seen_we;
    int          resp_cnt, resp_lat;

    always @(negedge clk) begin
        if (auto_en && (mem_read || mem_write) && !a_rdy) begin
            if (resp_cnt >= resp_lat) begin
                a_rdy      = 1'b1;
                a_data     = bus_mem.exists(mem_addr) ? bus_mem[mem_addr] : init_word(mem_addr);
                if (mem_write) bus_mem[mem_addr] = merge(a_data, mem_data, mem_be);
                if (mem_read && mem_write) a_data = 32'hBAD0BAD0;
                seen_addr  = mem_addr;
                seen_wdata = mem_data;
                seen_be    = mem_be;
                seen_we    = mem_write;
                resp_cnt   = 0;
                resp_lat   = $urandom_range(0, 3);
            end else begin
                resp_cnt++;
            end
        end else begin
            a_rdy = 1'b0;
            if (!auto_en) resp_cnt = 0;
        end
    end

    // Reference model: expected memory contents in request-completion order
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        nrst   = 1'b0;
        if_req = 1'b0;
        d_req  = 1'b0;
        m_rdy  = 1'b0;
        repeat (2) step();
        nrst   = 1'b1;
    endtask

    logic [31:0] f_a, x_a, x_w, exp_w, model_drd;
    logic [3:0]  x_be;
    logic        x_we, use_if, use_d, pend_if, pend_d, next_d, model_last_d;
    int          kind, cyc;

    initial begin
        total = 0; passed = 0;
        auto_en = 1'b0; a_rdy = 1'b0; a_data = 32'h0; resp_cnt = 0; resp_lat = 0;
        m_rdy = 1'b0; m_data = 32'h0;
        if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
        d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
        nrst = 1'b0;
        repeat (3) step();
        chk("rst_read", 32'(mem_read), 32'd0);
        chk("rst_write", 32'(mem_write), 32'd0);
        chk("rst_rdys", {29'd0, if_rdy, d_rdy, bus_err}, 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_data, 32'h0);
        chk("rst_be", 32'(mem_be), 32'h0);
        chk("rst_ifdata", if_data, 32'h0);
        chk("rst_drdata", d_rdata, 32'h0);
        nrst = 1'b1;

        // Fetch, ready on third strobe cycle
        if_req = 1'b1; if_addr = 32'h100;
        step();
        chk("t1_read_c1", 32'(mem_read), 32'd1);
        chk("t1_addr", mem_addr, 32'h100);
        chk("t1_be", 32'(mem_be), 32'hF);
        step();
        chk("t1_read_c2", 32'(mem_read), 32'd1);
        step();
        chk("t1_read_c3", 32'(mem_read), 32'd1);
        chk("t1_no_rdy_yet", 32'(if_rdy), 32'd0);
        m_rdy = 1'b1; m_data = 32'h00500093;
        step();
        chk("t1_ifrdy", 32'(if_rdy), 32'd1);
        chk("t1_read_off", 32'(mem_read), 32'd0);
        chk("t1_ifdata", if_data, 32'h00500093);
        if_req = 1'b0; m_rdy = 1'b0;
        step();
        chk("t1_ifrdy_pulse", 32'(if_rdy), 32'd0);
        chk("t1_ifdata_hold", if_data, 32'h00500093);

        // Store, ready held from before grant (ignored while idle)
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h203; d_wdata = 32'hDEADBEEF; d_be = 4'h8;
        m_rdy = 1'b1; m_data = 32'h77777777;
        step();
        chk("t2_write", 32'(mem_write), 32'd1);
        chk("t2_read", 32'(mem_read), 32'd0);
        chk("t2_addr", mem_addr, 32'h200);
        chk("t2_wdata", mem_data, 32'hDEADBEEF);
        chk("t2_be", 32'(mem_be), 32'h8);
        step();
        chk("t2_drdy", 32'(d_rdy), 32'd1);
        chk("t2_write_off", 32'(mem_write), 32'd0);
        chk("t2_drdata_keep", d_rdata, 32'h0);
        d_req = 1'b0; m_rdy = 1'b0;
        step();
        chk("t2_drdy_pulse", 32'(d_rdy), 32'd0);

        // Simultaneous requests after reset: D, IF, D while both held
        do_reset();
        if_req = 1'b1; if_addr = 32'h104;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_be = 4'h3;
        m_rdy = 1'b1; m_data = 32'h11111111;
        step();
        chk("t3_g1_addr", mem_addr, 32'h300);
        chk("t3_g1_be", 32'(mem_be), 32'h3);
        step();
        chk("t3_g1_rdy", {30'd0, if_rdy, d_rdy}, 32'd1);
        chk("t3_g1_data", d_rdata, 32'h11111111);
        m_data = 32'h22222222;
        step();
        chk("t3_g2_addr", mem_addr, 32'h104);
        chk("t3_g2_be", 32'(mem_be), 32'hF);
        step();
        chk("t3_g2_rdy", {30'd0, if_rdy, d_rdy}, 32'd2);
        chk("t3_g2_data", if_data, 32'h22222222);
        m_data = 32'h33333333;
        step();
        chk("t3_g3_addr", mem_addr, 32'h300);
        step();
        chk("t3_g3_rdy", {30'd0, if_rdy, d_rdy}, 32'd1);
        chk("t3_g3_data", d_rdata, 32'h33333333);
        if_req = 1'b0; d_req = 1'b0; m_rdy = 1'b0;
        step();

        // Reset during a fetch abandons it
        do_reset();
        if_req = 1'b1; if_addr = 32'h180;
        step();
        chk("t4_read", 32'(mem_read), 32'd1);
        nrst = 1'b0;
        step();
        chk("t4_read_abort", 32'(mem_read), 32'd0);
        chk("t4_no_rdy", 32'(if_rdy), 32'd0);
        nrst = 1'b1;
        step();
        chk("t4_regrant", 32'(mem_read), 32'd1);
        chk("t4_regrant_addr", mem_addr, 32'h180);
        m_rdy = 1'b1; m_data = 32'h0A0B0C0D;
        step();
        chk("t4_rdy", 32'(if_rdy), 32'd1);
        chk("t4_data", if_data, 32'h0A0B0C0D);
        if_req = 1'b0; m_rdy = 1'b0;
        step();

        // Load whose request drops right after grant still completes
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; d_be = 4'hF;
        step();
        chk("t6_read", 32'(mem_read), 32'd1);
        d_req = 1'b0;
        step();
        chk("t6_read_c2", 32'(mem_read), 32'd1);
        step();
        m_rdy = 1'b1; m_data = 32'hCAFEF00D;
        step();
        chk("t6_drdy", 32'(d_rdy), 32'd1);
        chk("t6_data", d_rdata, 32'hCAFEF00D);
        m_rdy = 1'b0;
        step();

`ifdef MEM_ARB_TIMEOUT_EN
        // Stuck bus times out after four strobe cycles
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_read_cycle", 32'(mem_read), 32'd1);
        end
        step();
        chk("t5_to_rdy", {30'd0, d_rdy, bus_err}, 32'd3);
        chk("t5_to_data", d_rdata, 32'h0);
        chk("t5_to_read", 32'(mem_read), 32'd0);
        d_req = 1'b0;
        step();
        chk("t5_err_pulse", 32'(bus_err), 32'd0);
        d_req = 1'b1; m_data = 32'h5A5A5A5A;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5b_read_cycle", 32'(mem_read), 32'd1);
        end
        m_rdy = 1'b1;
        step();
        chk("t5b_rdy", {30'd0, d_rdy, bus_err}, 32'd2);
        chk("t5b_data", d_rdata, 32'h5A5A5A5A);
        d_req = 1'b0; m_rdy = 1'b0;
        step();
`endif

        // Random traffic against the reference model
        do_reset();
        auto_en = 1'b1;
        model_last_d = 1'b0;
        model_drd = 32'h0;
        for (int it = 0; it < 40; it++) begin
            kind   = $urandom_range(0, 2);
            use_if = (kind != 1);
            use_d  = (kind != 0);
            f_a    = 32'($urandom_range(0, 63));
            x_a    = 32'($urandom_range(0, 63));
            x_we   = 1'($urandom_range(0, 1));
            x_w    = $urandom;
            x_be   = 4'($urandom_range(0, 15));
            next_d = (use_if && use_d) ? !model_last_d : use_d;
            if_req = use_if; if_addr = f_a;
            d_req = use_d; d_we = x_we; d_addr = x_a; d_wdata = x_w; d_be = x_be;
            pend_if = use_if; pend_d = use_d;
            cyc = 0;
            while ((pend_if || pend_d) && cyc < 40) begin
                step();
                cyc++;
                if (if_rdy || d_rdy) begin
                    chk("rnd_port", {30'd0, if_rdy, d_rdy}, next_d ? 32'd1 : 32'd2);
                    chk("rnd_err", 32'(bus_err), 32'd0);
                    if (d_rdy) begin
                        chk("rnd_d_addr", seen_addr, {x_a[31:2], 2'b00});
                        chk("rnd_d_op", {27'd0, seen_we, seen_be}, {27'd0, x_we, x_be});
                        if (x_we) begin
                            chk("rnd_d_wdata", seen_wdata, x_w);
                            ref_mem[{x_a[31:2], 2'b00}] = merge(ref_rd(x_a), x_w, x_be);
                        end else begin
                            model_drd = ref_rd(x_a);
                        end
                        chk("rnd_d_rdata", d_rdata, model_drd);
                        d_req = 1'b0; pend_d = 1'b0; model_last_d = 1'b1;
                    end else begin
                        exp_w = ref_rd(f_a);
                        chk("rnd_f_addr", seen_addr, {f_a[31:2], 2'b00});
                        chk("rnd_f_op", {27'd0, seen_we, seen_be}, 32'h0F);
                        chk("rnd_f_data", if_data, exp_w);
                        if_req = 1'b0; pend_if = 1'b0; model_last_d = 1'b0;
                    end
                    next_d = pend_d;
                end
            end
            chk("rnd_done", {30'd0, pend_if, pend_d}, 32'd0);
            if_req = 1'b0; d_req = 1'b0;
            repeat ($urandom_range(0, 2)) step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
